// File: rtl/bit_pattern_pkg.sv
// Shared definitions for the bit pattern generator: FSM state encoding,
// datapath widths and the legal run-length limit.
package bit_pattern_pkg;

    localparam int PAT_W     = 8;
    localparam int MAX_COUNT = 8;
    localparam int REM_W     = 4;
    localparam int ROT_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUILD  = 2'd1,
        S_ROTATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // One-step wrap-around left rotate of the pattern register.
    function automatic logic [PAT_W-1:0] rotl1(input logic [PAT_W-1:0] value);
        return {value[PAT_W-2:0], value[PAT_W-1]};
    endfunction

    // One-step shift that appends a 1 at bit 0, growing the run of ones.
    function automatic logic [PAT_W-1:0] grow1(input logic [PAT_W-1:0] value);
        return {value[PAT_W-2:0], 1'b1};
    endfunction

endpackage

// File: rtl/bit_pattern_gen_ctrl.sv
// Sequencing FSM for the bit pattern generator: decides when the datapath
// loads operands, grows the run of ones, rotates it, or flags a bad count.
module bit_pattern_gen_ctrl
    import bit_pattern_pkg::*;
(
    input  logic CLOCK_50,
    input  logic reset,
    input  logic start,
    input  logic rem_zero,
    input  logic rot_zero,
    input  logic rot_last,
    input  logic count_bad,
    output logic load,
    output logic shift,
    output logic rotate,
    output logic set_err,
    output logic busy,
    output logic done
);

    state_t state;
    state_t state_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last rotate step and the "nothing to rotate" case both hand off to
    // S_DONE directly, so a request costs N+P+2 edges including the start edge.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        rotate     = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!start) begin
                    load = 1'b1;
                end else if (count_bad) begin
                    set_err    = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_BUILD;
                end
            end
            S_BUILD: begin
                if (!rem_zero) begin
                    shift = 1'b1;
                end else if (rot_zero) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ROTATE;
                end
            end
            S_ROTATE: begin
                if (!rot_zero) begin
                    rotate = 1'b1;
                    if (rot_last) begin
                        state_next = S_DONE;
                    end
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    load       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_BUILD) || (state == S_ROTATE);
    assign done = (state == S_DONE);

endmodule

// File: rtl/bit_pattern_gen.sv
// Generates an 8-bit value holding a run of count_in ones whose lowest bit
// lands at pos_in (wrap-around), built one bit and one rotate step per cycle.
module bit_pattern_gen
    import bit_pattern_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [REM_W-1:0] count_in,
    input  logic [ROT_W-1:0] pos_in,
    output logic [PAT_W-1:0] pattern,
    output logic             done,
    output logic             busy,
    output logic             err
);

    logic [REM_W-1:0] rem;
    logic [ROT_W-1:0] rot;

    logic load;
    logic shift;
    logic rotate;
    logic set_err;

    logic rem_zero;
    logic rot_zero;
    logic rot_last;
    logic count_bad;

    assign rem_zero  = (rem == '0);
    assign rot_zero  = (rot == '0);
    assign rot_last  = (rot == ROT_W'(1));
    assign count_bad = (rem > REM_W'(MAX_COUNT));

    bit_pattern_gen_ctrl u_ctrl (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .rem_zero  (rem_zero),
        .rot_zero  (rot_zero),
        .rot_last  (rot_last),
        .count_bad (count_bad),
        .load      (load),
        .shift     (shift),
        .rotate    (rotate),
        .set_err   (set_err),
        .busy      (busy),
        .done      (done)
    );

    // Loading also fires on the S_DONE exit edge, so the result is cleared
    // on the same edge that done falls.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pattern <= '0;
            rem     <= '0;
            rot     <= '0;
            err     <= 1'b0;
        end else if (load) begin
            pattern <= '0;
            rem     <= count_in;
            rot     <= pos_in;
            err     <= 1'b0;
        end else begin
            if (set_err) begin
                err <= 1'b1;
            end
            // The FSM only strobes these while the matching counter is
            // non-zero, so neither counter can wrap below zero.
            if (shift) begin
                pattern <= grow1(pattern);
                rem     <= rem - REM_W'(1);
            end
            if (rotate) begin
                pattern <= rotl1(pattern);
                rot     <= rot - ROT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bit_pattern_gen.sv
// Directed self-checking bench for bit_pattern_gen: latency, busy span,
// wrap-around, bad counts, reset priority and operand capture.
module tb_bit_pattern_gen;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] count_in;
    logic [2:0] pos_in;
    logic [7:0] pattern;
    logic       done;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    bit_pattern_gen dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .count_in (count_in),
        .pos_in   (pos_in),
        .pattern  (pattern),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Wait for done with start already high; counts edges and busy cycles.
    task automatic wait_done(input string name, output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 64) begin
            step();
            edges++;
            if (busy) busy_cycles++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d edges", name, done, edges);
        end
    endtask

    // Load operands with start low, then raise start while scrambling the
    // operand inputs, which must have no effect on the result.
    task automatic run_op(input string name, input logic [3:0] cnt, input logic [2:0] pos,
                          output int edges, output int busy_cycles);
        start    = 1'b0;
        count_in = cnt;
        pos_in   = pos;
        step();
        start    = 1'b1;
        count_in = ~cnt;
        pos_in   = ~pos;
        wait_done(name, edges, busy_cycles);
    endtask

    task automatic release_start(input string name);
        start = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pattern !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s release: done=%b busy=%b pattern=%h err=%b, need 0 0 00 0",
                     name, done, busy, pattern, err);
        end
    endtask

    task automatic check_result(input string name, input int edges, input int exp_edges,
                                input logic [7:0] exp_pat, input logic exp_err);
        checks++;
        if (edges !== exp_edges) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, need %0d", name, edges, exp_edges);
        end
        checks++;
        if (pattern !== exp_pat) begin
            errors++;
            $display("FAIL %s pattern: got %h, need %h", name, pattern, exp_pat);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err: got %b, need %b", name, err, exp_err);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        count_in = 4'd0;
        pos_in   = 3'd0;
        step();
        step();
        checks++;
        if (pattern !== 8'h00 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pattern=%h done=%b busy=%b err=%b, need 00 0 0 0",
                     pattern, done, busy, err);
        end
    endtask

    task automatic test_start_after_reset();
        int edges;
        int bc;
        reset = 1'b1;
        step();
        reset    = 1'b0;
        start    = 1'b1;
        count_in = 4'd5;
        pos_in   = 3'd3;
        wait_done("start_after_reset", edges, bc);
        check_result("start_after_reset", edges, 2, 8'h00, 1'b0);
        release_start("start_after_reset");
    endtask

    task automatic test_basic();
        int edges;
        int bc;
        run_op("basic_3_0", 4'd3, 3'd0, edges, bc);
        check_result("basic_3_0", edges, 5, 8'h07, 1'b0);
        checks++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL basic_3_0 busy_cycles: got %0d, need 4", bc);
        end
        release_start("basic_3_0");
    endtask

    task automatic test_wrap();
        int edges;
        int bc;
        run_op("wrap_3_6", 4'd3, 3'd6, edges, bc);
        check_result("wrap_3_6", edges, 11, 8'hC1, 1'b0);
        release_start("wrap_3_6");
        run_op("wrap_1_7", 4'd1, 3'd7, edges, bc);
        check_result("wrap_1_7", edges, 10, 8'h80, 1'b0);
        release_start("wrap_1_7");
    endtask

    task automatic test_bounds();
        int edges;
        int bc;
        run_op("full_8_5", 4'd8, 3'd5, edges, bc);
        check_result("full_8_5", edges, 15, 8'hFF, 1'b0);
        release_start("full_8_5");
        run_op("empty_0_4", 4'd0, 3'd4, edges, bc);
        check_result("empty_0_4", edges, 6, 8'h00, 1'b0);
        release_start("empty_0_4");
    endtask

    task automatic test_illegal();
        int edges;
        int bc;
        run_op("illegal_9", 4'd9, 3'd2, edges, bc);
        check_result("illegal_9", edges, 1, 8'h00, 1'b1);
        checks++;
        if (bc !== 0) begin
            errors++;
            $display("FAIL illegal_9 busy_cycles: got %0d, need 0", bc);
        end
        release_start("illegal_9");
        run_op("illegal_15", 4'd15, 3'd7, edges, bc);
        check_result("illegal_15", edges, 1, 8'h00, 1'b1);
        release_start("illegal_15");
    endtask

    task automatic test_reset_mid();
        int edges;
        int bc;
        start    = 1'b0;
        count_in = 4'd5;
        pos_in   = 3'd2;
        step();
        start = 1'b1;
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b1 || pattern !== 8'h03) begin
            errors++;
            $display("FAIL reset_mid pre: busy=%b pattern=%h, need 1 03", busy, pattern);
        end
        reset = 1'b1;
        step();
        checks++;
        if (pattern !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid post: pattern=%h busy=%b done=%b err=%b, need 00 0 0 0",
                     pattern, busy, done, err);
        end
        reset    = 1'b0;
        count_in = 4'd6;
        pos_in   = 3'd6;
        wait_done("reset_mid_restart", edges, bc);
        check_result("reset_mid_restart", edges, 2, 8'h00, 1'b0);
        release_start("reset_mid_restart");
    endtask

    task automatic test_hold();
        int edges;
        int bc;
        run_op("hold_2_1", 4'd2, 3'd1, edges, bc);
        check_result("hold_2_1", edges, 5, 8'h06, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (done !== 1'b1 || pattern !== 8'h06) begin
                errors++;
                $display("FAIL hold_done cycle %0d: done=%b pattern=%h, need 1 06", i, done, pattern);
            end
        end
        release_start("hold_2_1");
    endtask

    task automatic test_back_to_back();
        int edges;
        int bc;
        run_op("b2b_first", 4'd4, 3'd2, edges, bc);
        check_result("b2b_first", edges, 8, 8'h3C, 1'b0);
        start = 1'b0;
        count_in = 4'd2;
        pos_in   = 3'd7;
        step();
        start    = 1'b1;
        count_in = 4'd8;
        pos_in   = 3'd0;
        wait_done("b2b_second", edges, bc);
        check_result("b2b_second", edges, 11, 8'h81, 1'b0);
        release_start("b2b_second");
    endtask

    initial begin
        test_reset();
        reset = 1'b0;
        test_start_after_reset();
        test_basic();
        test_wrap();
        test_bounds();
        test_illegal();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
